// File: rtl/spi_chip_responder.sv
// spi_chip_responder
//   Chip-side SPI register file used as a loopback target and as a reference
//   peer for SPI driver benches. spi_clk/mosi are oversampled in the clk domain
//   (no chip select); frames are delimited by an idle timeout.
//   Frames: 01,ADDR,WDATA (single write) or 02,ADDR,COUNT then COUNT bytes on miso.
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   spi_clk, mosi     SPI clock/data from the driver (asynchronous, clock idles low)
//   miso              SPI data to the driver, 0 outside read data bytes
//   host_we/addr/wdata/rdata  backdoor register access, rdata has 1-cycle latency
//   wr_event(+_addr/_data)    pulse and details of each committed SPI write
//   rd_byte_done      pulse per read byte fully shifted out
//   frame_error       pulse on bad opcode or a frame truncated by the timeout
module spi_chip_responder #(
  parameter int unsigned REG_COUNT    = 256,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       mosi,
  output logic       miso,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       wr_event,
  output logic [7:0] wr_event_addr,
  output logic [7:0] wr_event_data,
  output logic       rd_byte_done,
  output logic       frame_error
);

  localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [8:0]    REG_LIMIT    = 9'(REG_COUNT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMEOUT_FULL = TW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR,
    S_WDATA,
    S_COUNT,
    S_RDATA,
    S_DISCARD
  } state_e;

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < REG_LIMIT;
  endfunction

  // [0] first sync stage, [1] second sync stage, [2] previous value for edge detect
  logic [2:0]    sclk_sync_q;
  logic [1:0]    mosi_sync_q;
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shift_in_q;
  logic          is_read_q;
  logic [7:0]    ptr_q;
  logic [7:0]    remain_q;
  logic [7:0]    shift_out_q;
  logic          miso_q;
  logic [TW-1:0] idle_cnt_q;
  logic [7:0]    regs_q [REG_COUNT];
  logic [7:0]    host_rdata_q;
  logic [7:0]    wr_addr_q;
  logic [7:0]    wr_data_q;
  logic          wr_event_q;
  logic          rd_byte_done_q;
  logic          frame_error_q;

  logic       sclk_rise;
  logic       sclk_fall;
  logic       timeout;
  logic       mid_frame;
  logic [7:0] rx_byte;
  logic [7:0] load_addr;
  logic [7:0] load_data;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  // Fires exactly once per idle period: on the cycle the counter would reach the limit.
  assign timeout   = !sclk_rise && (idle_cnt_q == TIMEOUT_LAST);
  assign mid_frame = (state_q != S_OPCODE) || (bit_cnt_q != 3'd0);
  assign rx_byte   = {shift_in_q, mosi_sync_q[1]};

  // First read byte comes from ptr, every following one from ptr+1 (8-bit wrap).
  assign load_addr = (state_q == S_COUNT) ? ptr_q : ptr_q + 8'd1;
  assign load_data = in_range(load_addr) ? regs_q[load_addr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q    <= '0;
      mosi_sync_q    <= '0;
      state_q        <= S_OPCODE;
      bit_cnt_q      <= '0;
      shift_in_q     <= '0;
      is_read_q      <= 1'b0;
      ptr_q          <= '0;
      remain_q       <= '0;
      shift_out_q    <= '0;
      miso_q         <= 1'b0;
      idle_cnt_q     <= '0;
      host_rdata_q   <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_event_q     <= 1'b0;
      rd_byte_done_q <= 1'b0;
      frame_error_q  <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[AW'(i)] <= '0;
      end
    end else begin
      wr_event_q     <= 1'b0;
      rd_byte_done_q <= 1'b0;
      frame_error_q  <= 1'b0;

      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};

      host_rdata_q <= in_range(host_addr) ? regs_q[host_addr[AW-1:0]] : '0;
      if (host_we && in_range(host_addr)) begin
        regs_q[host_addr[AW-1:0]] <= host_wdata;
      end

      if (sclk_rise) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != TIMEOUT_FULL) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end

      if (timeout) begin
        if (mid_frame && (state_q != S_DISCARD)) begin
          frame_error_q <= 1'b1;
        end
        state_q   <= S_OPCODE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else if (sclk_rise) begin
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        shift_in_q <= rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            S_OPCODE: begin
              if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                is_read_q <= rx_byte[1];
                state_q   <= S_ADDR;
              end else begin
                state_q       <= S_DISCARD;
                frame_error_q <= 1'b1;
              end
            end
            S_ADDR: begin
              ptr_q   <= rx_byte;
              state_q <= is_read_q ? S_COUNT : S_WDATA;
            end
            S_WDATA: begin
              // Placed after the host write so the SPI commit wins on a same-address collision.
              if (in_range(ptr_q)) begin
                regs_q[ptr_q[AW-1:0]] <= rx_byte;
                wr_event_q            <= 1'b1;
                wr_addr_q             <= ptr_q;
                wr_data_q             <= rx_byte;
              end
              state_q <= S_OPCODE;
            end
            S_COUNT: begin
              if (rx_byte == 8'h00) begin
                state_q <= S_OPCODE;
              end else begin
                remain_q    <= rx_byte;
                shift_out_q <= load_data;
                state_q     <= S_RDATA;
              end
            end
            S_RDATA: begin
              rd_byte_done_q <= 1'b1;
              remain_q       <= remain_q - 8'd1;
              ptr_q          <= ptr_q + 8'd1;
              if (remain_q == 8'd1) begin
                state_q <= S_OPCODE;
                miso_q  <= 1'b0;
              end else begin
                shift_out_q <= load_data;
              end
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == S_RDATA) begin
        // The byte is loaded on the 8th rising edge, so the following falling edge
        // presents its MSB; each later falling edge advances one bit.
        miso_q      <= shift_out_q[7];
        shift_out_q <= {shift_out_q[6:0], 1'b0};
      end
    end
  end

  assign miso          = miso_q;
  assign host_rdata    = host_rdata_q;
  assign wr_event      = wr_event_q;
  assign wr_event_addr = wr_addr_q;
  assign wr_event_data = wr_data_q;
  assign rd_byte_done  = rd_byte_done_q;
  assign frame_error   = frame_error_q;

endmodule
